// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
//  Module   : arb_requester
//  Purpose  : Requester side of a request/grant arbitration handshake.
//             Accepts a local job (a burst of job_len beats), raises a
//             registered request towards an arbiter, counts granted beats,
//             abandons the job if no grant arrives within TIMEOUT_CYC cycles,
//             and enforces a request-low gap of GAP_CYC cycles between jobs.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LEN_W        width of job_len
//    TIMEOUT_CYC  REQ-state cycles without grant before abandoning (1..255)
//    GAP_CYC      request-low cycles between jobs (0..15)
//  Ports
//    clk          clock, rising edge
//    reset_n      asynchronous active-low reset
//    job_valid    local job present
//    job_len      beats requested (0 is treated as 1)
//    job_ready    block is idle and can accept a job
//    request      registered request to the arbiter
//    grant        grant from the arbiter
//    beat_en      one granted data beat this cycle (request && grant)
//    busy         block is not idle
//    done         pulse on the last beat of a job
//    timeout      pulse when a job is abandoned
//    timeout_cnt  saturating count of abandoned jobs
// ============================================================================
module arb_requester #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             request,
  input  logic             grant,
  output logic             beat_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [7:0]       timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Where a finished or abandoned job goes: straight back to IDLE when no
  // inter-job gap is configured, otherwise through GAP.
  localparam state_t         END_STATE    = (GAP_CYC == 0) ? IDLE : GAP;
  localparam logic [7:0]     TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     GAP_LAST     = 4'(GAP_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_next;
  logic [7:0]       wait_cnt;
  logic [7:0]       wait_next;
  logic [3:0]       gap_cnt;
  logic [3:0]       gap_next;
  logic             req_q;
  logic             req_next;
  logic             timeout_q;
  logic             timeout_next;
  logic [7:0]       tcnt_q;
  logic [7:0]       tcnt_next;
  logic             done_c;

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  assign job_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign request     = req_q;
  // Gating with the registered request masks the trailing grant cycle a
  // registered arbiter produces after request has dropped.
  assign beat_en     = req_q && grant;
  assign done        = done_c;
  assign timeout     = timeout_q;
  assign timeout_cnt = tcnt_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state     <= state_next;
      len_q     <= len_next;
      remaining <= remaining_next;
      wait_cnt  <= wait_next;
      gap_cnt   <= gap_next;
      req_q     <= req_next;
      timeout_q <= timeout_next;
      tcnt_q    <= tcnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and pulse logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    len_next       = len_q;
    remaining_next = remaining;
    wait_next      = wait_cnt;
    gap_next       = gap_cnt;
    timeout_next   = 1'b0;
    tcnt_next      = tcnt_q;
    done_c         = 1'b0;

    case (state)
      IDLE: begin
        if (job_valid) begin
          len_next   = (job_len == '0) ? LEN_ONE : job_len;
          wait_next  = '0;
          state_next = REQ;
        end
      end

      REQ: begin
        if (beat_en) begin
          if (len_q == LEN_ONE) begin
            // Single-beat job completes on its first granted cycle.
            done_c     = 1'b1;
            gap_next   = '0;
            state_next = END_STATE;
          end else begin
            remaining_next = len_q - LEN_ONE;
            state_next     = BURST;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          // This ungranted cycle brings the wait count to TIMEOUT_CYC.
          // The timeout pulse is registered so it appears in the first
          // cycle after request drops and can never overlap done.
          timeout_next = 1'b1;
          if (tcnt_q != 8'hFF) begin
            tcnt_next = tcnt_q + 8'd1;
          end
          gap_next   = '0;
          state_next = END_STATE;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end

      BURST: begin
        // A stalled burst simply waits: no timeout is applied here.
        if (beat_en) begin
          if (remaining == LEN_ONE) begin
            done_c         = 1'b1;
            remaining_next = '0;
            gap_next       = '0;
            state_next     = END_STATE;
          end else begin
            remaining_next = remaining - LEN_ONE;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Request follows the next state so that it is a clean flop output that
    // rises the cycle after acceptance and falls with the last beat.
    req_next = (state_next == REQ) || (state_next == BURST);
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_arb_requester
//  Purpose  : Self-checking bench for arb_requester paired with a
//             one-cycle-registered arbiter model (grant follows request by one
//             clock, with a gate to hold grant low).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

  localparam int LEN_W       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int GAP_CYC     = 2;
  localparam int MAX_CYC     = 200;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             request;
  logic             grant;
  logic             beat_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [7:0]       timeout_cnt;

  logic arb_q;
  logic arb_on;
  logic force_low;

  int compared   = 0;
  int mismatched = 0;
  int exp_tcnt   = 0;

  typedef struct {
    int beats;
    bit is_to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_beats = 0;

  typedef struct {
    logic [LEN_W-1:0] len;
    bit               use_arb;
    int               stall_after;
    int               beats;
    int               req_cyc;
    int               first;
    bit               is_to;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  // Registered arbiter: grants the cycle after it sees request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) arb_q <= 1'b0;
    else          arb_q <= request;
  end
  assign grant = arb_q & arb_on & ~force_low;

  arb_requester #(
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_valid  (job_valid),
    .job_len    (job_len),
    .job_ready  (job_ready),
    .request    (request),
    .grant      (grant),
    .beat_en    (beat_en),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .timeout_cnt(timeout_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard consumer: every done/timeout pulse retires one expected job.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_beats = 0;
    end else begin
      if (beat_en === 1'b1) mon_beats++;
      if (done === 1'b1 || timeout === 1'b1) begin
        check("done_timeout_exclusive", {31'd0, done & timeout}, 0);
        if (sb.size() == 0) begin
          check("sb_unexpected_event", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_is_timeout", {31'd0, timeout}, {31'd0, mon_e.is_to});
          check("sb_beats", mon_beats, mon_e.beats);
        end
        mon_beats = 0;
      end
    end
  end

  // Drive one job and measure it cycle by cycle. Cycle 1 is the first cycle
  // after the acceptance edge.
  task automatic run_job(input string tag, input logic [LEN_W-1:0] len,
                         input bit use_arb, input int stall_after,
                         input int exp_beats, input int exp_req,
                         input int exp_first, input bit exp_to);
    int rq = 0, bt = 0, first = 0, dn = 0, to = 0, idx = 0, stall_ctr = 0;
    bit stalled = 1'b0, finished = 1'b0, new_force;
    logic req_at1 = 1'b0;
    @(negedge clk);
    check({tag, "_ready_before"}, {31'd0, job_ready}, 1);
    arb_on    = use_arb;
    job_valid = 1'b1;
    job_len   = len;
    sb.push_back('{beats: exp_beats, is_to: exp_to});
    @(negedge clk);
    job_valid = 1'b0;
    for (int i = 1; i <= MAX_CYC; i++) begin
      if (i > 1) @(negedge clk);
      if (job_ready === 1'b1) begin
        idx      = i;
        finished = 1'b1;
        break;
      end
      if (i == 1) req_at1 = request;
      if (request === 1'b1) rq++;
      if (beat_en === 1'b1) begin
        bt++;
        if (first == 0) first = i;
      end
      if (done === 1'b1)    dn++;
      if (timeout === 1'b1) to++;
      new_force = force_low;
      if (stall_after > 0 && bt == stall_after && !stalled) begin
        new_force = 1'b1;
        stall_ctr = 3;
        stalled   = 1'b1;
      end else if (stall_ctr > 0) begin
        stall_ctr--;
        if (stall_ctr == 0) new_force = 1'b0;
      end
      // Grant changes only just after a rising edge so the beat seen at the
      // negedge is the one the DUT commits.
      @(posedge clk);
      #1 force_low = new_force;
    end
    force_low = 1'b0;
    check({tag, "_finished_in_bound"}, {31'd0, finished}, 1);
    check({tag, "_req_after_accept"}, {31'd0, req_at1}, 1);
    check({tag, "_req_cycles"}, rq, exp_req);
    check({tag, "_beats"}, bt, exp_beats);
    check({tag, "_first_beat_cycle"}, first, exp_first);
    check({tag, "_done_pulses"}, dn, exp_to ? 0 : 1);
    check({tag, "_timeout_pulses"}, to, exp_to ? 1 : 0);
    check({tag, "_ready_cycle"}, idx, exp_req + GAP_CYC + 1);
    if (exp_to && exp_tcnt < 255) exp_tcnt++;
    check({tag, "_timeout_cnt"}, {24'd0, timeout_cnt}, exp_tcnt);
  endtask

  initial begin
    int bt;
    // len, arb, stall_after, beats, req cycles, first beat cycle, timeout
    tbl[0] = '{len: 4'd3,  use_arb: 1'b1, stall_after: 0, beats: 3,  req_cyc: 4,  first: 2, is_to: 1'b0};
    tbl[1] = '{len: 4'd0,  use_arb: 1'b1, stall_after: 0, beats: 1,  req_cyc: 2,  first: 2, is_to: 1'b0};
    tbl[2] = '{len: 4'd1,  use_arb: 1'b1, stall_after: 0, beats: 1,  req_cyc: 2,  first: 2, is_to: 1'b0};
    tbl[3] = '{len: 4'd15, use_arb: 1'b1, stall_after: 0, beats: 15, req_cyc: 16, first: 2, is_to: 1'b0};
    tbl[4] = '{len: 4'd4,  use_arb: 1'b1, stall_after: 2, beats: 4,  req_cyc: 8,  first: 2, is_to: 1'b0};
    tbl[5] = '{len: 4'd5,  use_arb: 1'b0, stall_after: 0, beats: 0,  req_cyc: 16, first: 0, is_to: 1'b1};
    tbl[6] = '{len: 4'd2,  use_arb: 1'b1, stall_after: 0, beats: 2,  req_cyc: 3,  first: 2, is_to: 1'b0};

    reset_n   = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    arb_on    = 1'b1;
    force_low = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_request",     {31'd0, request},     0);
    check("rst_beat_en",     {31'd0, beat_en},     0);
    check("rst_done",        {31'd0, done},        0);
    check("rst_timeout",     {31'd0, timeout},     0);
    check("rst_timeout_cnt", {24'd0, timeout_cnt}, 0);
    check("rst_busy",        {31'd0, busy},        0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready",  {31'd0, job_ready},   1);

    for (int v = 0; v < 7; v++) begin
      run_job($sformatf("vec%0d", v), tbl[v].len, tbl[v].use_arb,
              tbl[v].stall_after, tbl[v].beats, tbl[v].req_cyc,
              tbl[v].first, tbl[v].is_to);
    end

    // Reset in the middle of a 5-beat burst, just after beat 2 is taken.
    @(negedge clk);
    arb_on    = 1'b1;
    job_valid = 1'b1;
    job_len   = 4'd5;
    @(negedge clk);
    job_valid = 1'b0;
    bt = 0;
    for (int i = 0; i < MAX_CYC && bt < 2; i++) begin
      if (i > 0) @(negedge clk);
      if (beat_en === 1'b1) bt++;
    end
    check("mid_rst_two_beats_seen", bt, 2);
    @(posedge clk);
    #1;
    check("mid_rst_request_before", {31'd0, request}, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_request_async", {31'd0, request},     0);
    check("mid_rst_beat_en",       {31'd0, beat_en},     0);
    check("mid_rst_busy",          {31'd0, busy},        0);
    check("mid_rst_done",          {31'd0, done},        0);
    check("mid_rst_timeout_cnt",   {24'd0, timeout_cnt}, 0);
    exp_tcnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", {31'd0, job_ready}, 1);
    check("mid_rst_idle_after",  {31'd0, busy},      0);

    // Post-reset sanity job, then saturate the abandoned-job counter.
    run_job("after_rst", 4'd3, 1'b1, 0, 3, 4, 2, 1'b0);
    for (int n = 0; n < 300; n++) begin
      run_job("sat", 4'd1, 1'b0, 0, 0, 16, 0, 1'b1);
    end
    check("sat_timeout_cnt", {24'd0, timeout_cnt}, 255);
    check("sb_empty_at_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, width of the job_len burst-length field.
REQ-002 Parameter TIMEOUT_CYC, default 16, number of REQ-state cycles without grant before the job is abandoned (legal range 1..255).
REQ-003 Parameter GAP_CYC, default 2, minimum number of request-low cycles between jobs (legal range 0..15).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 job_valid  input  1  local job present.
REQ-007 job_len  input  LEN_W  beats requested; 0 is treated as 1.
REQ-008 job_ready  output  1  block can accept a job.
REQ-009 request  output  1  registered request to the arbiter.
REQ-010 grant  input  1  grant from the arbiter.
REQ-011 beat_en  output  1  one granted data beat this cycle.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse when the last beat of a job completes.
REQ-014 timeout  output  1  one-cycle pulse when a job is abandoned.
REQ-015 timeout_cnt  output  8  count of abandoned jobs, saturating.

Function
REQ-016 FSM states SHALL be IDLE, REQ, BURST and GAP.
REQ-017 job_ready SHALL equal (state==IDLE); a job SHALL be accepted on a rising edge where job_valid && job_ready, latching job_len (0 mapped to 1) and moving to REQ.
REQ-018 request SHALL be registered and SHALL be 1 exactly while state is REQ or BURST, i.e. it rises the cycle after job acceptance.
REQ-019 beat_en SHALL equal request && grant; grant SHALL be ignored in IDLE and GAP.
REQ-020 In REQ, a wait counter SHALL clear on entry and increment each cycle with grant=0.
REQ-021 In REQ with grant=1: if the latched length is 1, the FSM SHALL go to GAP and pulse done on that same beat cycle; otherwise it SHALL go to BURST with remaining = len-1.
REQ-022 In REQ, once the wait counter reaches TIMEOUT_CYC with grant still 0, the FSM SHALL go to GAP, pulse timeout for one cycle, discard the job, and increment timeout_cnt, which saturates at 255.
REQ-023 In BURST, each grant=1 cycle SHALL decrement remaining; the beat that brings remaining to 0 SHALL pulse done and move the FSM to GAP.
REQ-024 In BURST, grant=0 SHALL stall: request stays high, no beat is counted, and no timeout applies.
REQ-025 GAP SHALL last exactly GAP_CYC cycles with request=0 and then return to IDLE; when GAP_CYC=0 the FSM SHALL go directly to IDLE.
REQ-026 The trailing grant cycle from a registered arbiter (grant still 1 after request drops) SHALL produce no beat_en.
REQ-027 done and timeout SHALL never assert in the same cycle.
REQ-028 With a one-cycle-registered arbiter, acceptance at edge T SHALL give request=1 after T, and the first beat_en in the following cycle.

Reset
REQ-029 While reset_n=0: state=IDLE, request=0, beat_en=0, done=0, timeout=0, timeout_cnt=0, all counters cleared, and busy=0.
REQ-030 Reset asserted mid-job SHALL drop request immediately (asynchronously) and discard the job without a done or timeout pulse.
REQ-031 After reset release, job_ready SHALL be 1 on the first clock.

Verification
REQ-032 Bench SHALL pair the block with the registered arbiter, job_len=3 -> request high 4 cycles, beat_en high 3 consecutive cycles, done on beat 3, request low for 2 cycles, then job_ready=1.
REQ-033 job_len=0 -> exactly 1 beat_en and done on that beat.
REQ-034 grant tied 0, TIMEOUT_CYC=16 -> timeout pulse after 16 REQ cycles, timeout_cnt=1, no beat_en, and no done.
REQ-035 job_len=4 with grant forced 0 for 3 cycles mid-burst -> request held, still exactly 4 beat_en pulses, and a single done.
REQ-036 300 consecutive timeouts -> timeout_cnt saturates at 255.
REQ-037 reset_n pulsed low in BURST after beat 2 of 5 -> request=0 asynchronously, no done, and the block is idle and ready after release.
